// File: rtl/apb_requester_mux_if.sv
// apb_requester_mux_if: request/response channel plus APB completer bus of the requester bridge
interface apb_requester_mux_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int COMP       = 4
);
  logic                       MVALID;
  logic                       MREADY;
  logic                       MWRITE;
  logic [ADDR_WIDTH-1:0]      MADDR;
  logic [DATA_WIDTH-1:0]      MWDATA;
  logic [DATA_WIDTH/8-1:0]    MSTRB;
  logic [2:0]                 MPROT;
  logic                       MRESP_VALID;
  logic                       MRESP_READY;
  logic [DATA_WIDTH-1:0]      MRDATA;
  logic                       MERR;
  logic [COMP-1:0]            PSELx;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [ADDR_WIDTH-1:0]      PADDR;
  logic [DATA_WIDTH-1:0]      PWDATA;
  logic [DATA_WIDTH/8-1:0]    PSTRB;
  logic [2:0]                 PPROT;
  logic [COMP-1:0]            PREADY;
  logic [COMP-1:0]            PSLVERR;
  logic [COMP*DATA_WIDTH-1:0] PRDATA;
  modport master (
    output MVALID, MWRITE, MADDR, MWDATA, MSTRB, MPROT, MRESP_READY, PREADY, PSLVERR, PRDATA,
    input  MREADY, MRESP_VALID, MRDATA, MERR, PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
  );
  modport slave (
    input  MVALID, MWRITE, MADDR, MWDATA, MSTRB, MPROT, MRESP_READY, PREADY, PSLVERR, PRDATA,
    output MREADY, MRESP_VALID, MRDATA, MERR, PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
  );
endinterface

// File: rtl/apb_requester_mux.sv
// apb_requester_mux: APB4 requester bridge with address decode over COMP completers; APB_REQUESTER_TIMEOUT_EN adds a wait-state timeout
module apb_requester_mux #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int COMP           = 4,
  parameter int REGION_BITS    = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic PCLK,
  input logic PRESETn,
  apb_requester_mux_if.slave bus
);
  localparam int FW = $clog2(COMP);
  localparam int IW = FW > 0 ? FW : 1;
  localparam int SW = DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic                  wr, err, hit, p_rdy, p_err, tmo;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata, rdata;
  logic [SW-1:0]         strb;
  logic [2:0]            prot;
  logic [IW-1:0]         idx, idx_d;
  assign idx_d = FW > 0 ? IW'(bus.MADDR >> REGION_BITS) : '0;
  assign hit   = ((bus.MADDR >> (REGION_BITS + FW)) == '0) && (32'(idx_d) < COMP);
  assign p_rdy = bus.PREADY[idx];
  assign p_err = bus.PSLVERR[idx];
`ifdef APB_REQUESTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // count wait states of the current access, restarting at each SETUP
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) cnt <= '0;
    else if (state == SETUP) cnt <= '0;
    else if (state == ACCESS && !p_rdy) cnt <= cnt + CW'(1);
  assign tmo = state == ACCESS && !p_rdy && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = TIMEOUT_CYCLES < 0;
`endif
  // state register
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) state <= IDLE;
    else state <= state_n;
  // next-state: decode errors skip the APB phases and go straight to RESP
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.MVALID) state_n = hit ? SETUP : RESP;
      SETUP:   state_n = ACCESS;
      ACCESS:  if (p_rdy || tmo) state_n = RESP;
      default: if (bus.MRESP_READY) state_n = IDLE;
    endcase
  end
  // capture the request on accept and the completion status when the access ends
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      wr    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      strb  <= '0;
      prot  <= '0;
      idx   <= '0;
      err   <= 1'b0;
      rdata <= '0;
    end else if (state == IDLE && bus.MVALID) begin
      wr    <= bus.MWRITE;
      addr  <= bus.MADDR;
      wdata <= bus.MWDATA;
      strb  <= bus.MSTRB;
      prot  <= bus.MPROT;
      idx   <= idx_d;
      err   <= !hit;
      rdata <= '0;
    end else if (state == ACCESS && p_rdy) begin
      err   <= p_err;
      rdata <= (!wr && !p_err) ? bus.PRDATA[32'(idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
    end else if (tmo) begin
      err   <= 1'b1;
      rdata <= '0;
    end
  assign bus.MREADY      = state == IDLE && PRESETn;
  assign bus.MRESP_VALID = state == RESP;
  assign bus.MRDATA      = rdata;
  assign bus.MERR        = err;
  assign bus.PSELx       = (state == SETUP || state == ACCESS) ? COMP'(1) << idx : '0;
  assign bus.PENABLE     = state == ACCESS;
  assign bus.PWRITE      = wr;
  assign bus.PADDR       = addr;
  assign bus.PWDATA      = wdata;
  assign bus.PSTRB       = wr ? strb : '0;
  assign bus.PPROT       = prot;
endmodule

// File: tb/tb_apb_requester_mux.sv
// tb_apb_requester_mux: scoreboard bench for the APB requester bridge
module tb_apb_requester_mux;
`ifdef APB_REQUESTER_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 256;
`endif
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  apb_requester_mux_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .COMP(4)) bus();
  apb_requester_mux #(.TIMEOUT_CYCLES(TO)) dut (.PCLK(PCLK), .PRESETn(PRESETn), .bus(bus));
  always #5 PCLK = ~PCLK;
  // cycle counter used to measure response latency
  always @(posedge PCLK) cyc <= cyc + 1;
  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          lat;
    logic [3:0]  sel;
    int          nacc;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic        w;
    int          acc;
  } exp_t;
  exp_t        q[$];
  int          wait_n[4];
  logic        slverr[4];
  logic [31:0] prdata[4];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=expired required=event", name);
  endtask
  // completer models: selected one inserts wait_n wait states, unselected ones drive ready/error noise
  initial begin
    int wc[4];
    wc = '{0, 0, 0, 0};
    forever begin
      @(negedge PCLK);
      for (int i = 0; i < 4; i++) begin
        bus.PRDATA[i*32 +: 32] = prdata[i];
        if (bus.PSELx[i] && bus.PENABLE) begin
          bus.PREADY[i]  = wc[i] == wait_n[i];
          bus.PSLVERR[i] = slverr[i];
          wc[i]++;
        end else begin
          bus.PREADY[i]  = !bus.PSELx[i];
          bus.PSLVERR[i] = 1'b1;
          wc[i] = 0;
        end
      end
    end
  end
  // monitor: checks APB phases against the head of the scoreboard and pops on each new response
  initial begin
    int          en_cnt = 0;
    logic        seen = 1'b0;
    logic        h_err = 1'b0;
    logic [31:0] h_rd = '0;
    exp_t        e;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        en_cnt = 0;
        seen   = 1'b0;
      end else begin
        if (|bus.PSELx) begin
          if (q.size() == 0) flag("stray_psel");
          else begin
            chk("psel", 32'(bus.PSELx), 32'(q[0].sel));
            chk("pstrb", 32'(bus.PSTRB), 32'(q[0].strb));
            chk("paddr", bus.PADDR, q[0].addr);
            chk("pwrite", 32'(bus.PWRITE), 32'(q[0].w));
            chk("pprot", 32'(bus.PPROT), 32'd2);
          end
        end
        if (bus.PENABLE) en_cnt++;
        if (bus.MRESP_VALID) begin
          chk("mready_busy", 32'(bus.MREADY), 32'd0);
          if (!seen) begin
            if (q.size() == 0) flag("unexpected_resp");
            else begin
              e = q.pop_front();
              chk("merr", 32'(bus.MERR), 32'(e.err));
              chk("mrdata", bus.MRDATA, e.rd);
              chk("latency", 32'(cyc - e.acc), 32'(e.lat));
              chk("access_cycles", 32'(en_cnt), 32'(e.nacc));
            end
            en_cnt = 0;
            h_err  = bus.MERR;
            h_rd   = bus.MRDATA;
          end else begin
            chk("merr_hold", 32'(bus.MERR), 32'(h_err));
            chk("mrdata_hold", bus.MRDATA, h_rd);
          end
        end
        seen = bus.MRESP_VALID;
      end
    end
  end
  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic e_err, input logic [31:0] e_rd, input int lat, input logic [3:0] sel, input int nacc);
    int n = 0;
    bus.MWRITE = w;
    bus.MADDR  = a;
    bus.MWDATA = d;
    bus.MSTRB  = s;
    bus.MPROT  = 3'b010;
    bus.MVALID = 1'b1;
    while (!bus.MREADY && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    if (!bus.MREADY) flag("accept_timeout");
    q.push_back('{e_err, e_rd, lat, sel, nacc, w ? s : 4'h0, a, w, cyc});
    @(negedge PCLK);
    bus.MVALID = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while ((q.size() != 0 || bus.MRESP_VALID) && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    if (n == 200) flag("resp_timeout");
  endtask
  initial begin
    int n;
    wait_n = '{0, 0, 0, 0};
    slverr = '{1'b0, 1'b0, 1'b0, 1'b0};
    prdata = '{32'h11111111, 32'h22222222, 32'hA5A5A5A5, 32'h12345678};
    bus.MVALID = 1'b0;
    bus.MWRITE = 1'b0;
    bus.MADDR = '0;
    bus.MWDATA = '0;
    bus.MSTRB = '0;
    bus.MPROT = '0;
    bus.MRESP_READY = 1'b1;
    repeat (3) @(negedge PCLK);
    chk("rst_mready", 32'(bus.MREADY), 32'd0);
    chk("rst_mresp_valid", 32'(bus.MRESP_VALID), 32'd0);
    chk("rst_psel", 32'(bus.PSELx), 32'd0);
    chk("rst_penable", 32'(bus.PENABLE), 32'd0);
    chk("rst_merr", 32'(bus.MERR), 32'd0);
    chk("rst_mrdata", bus.MRDATA, 32'd0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("rel_mready", 32'(bus.MREADY), 32'd1);
    req(1'b1, 32'h0000_1010, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 3, 4'b0010, 1);
    wait_done();
    wait_n[3] = 3;
    req(1'b0, 32'h0000_3004, 32'h0, 4'hF, 1'b0, 32'h12345678, 6, 4'b1000, 4);
    wait_done();
    wait_n[3] = 0;
    req(1'b0, 32'h0001_0000, 32'h0, 4'h0, 1'b1, 32'h0, 1, 4'b0000, 0);
    wait_done();
    req(1'b0, 32'h0000_4000, 32'h0, 4'h0, 1'b1, 32'h0, 1, 4'b0000, 0);
    wait_done();
    slverr[2] = 1'b1;
    bus.MRESP_READY = 1'b0;
    req(1'b1, 32'h0000_2000, 32'hCAFEF00D, 4'h3, 1'b1, 32'h0, 3, 4'b0100, 1);
    n = 0;
    while (!bus.MRESP_VALID && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    if (!bus.MRESP_VALID) flag("slverr_resp_wait");
    repeat (5) @(negedge PCLK);
    bus.MRESP_READY = 1'b1;
    wait_done();
    req(1'b0, 32'h0000_2100, 32'h0, 4'hF, 1'b1, 32'h0, 3, 4'b0100, 1);
    wait_done();
    slverr[2] = 1'b0;
    wait_n[2] = 1;
    req(1'b0, 32'h0000_2FFC, 32'h0, 4'hF, 1'b0, 32'hA5A5A5A5, 4, 4'b0100, 2);
    wait_done();
    wait_n[2] = 0;
    wait_n[0] = 1000;
    req(1'b0, 32'h0000_0000, 32'h0, 4'hF, 1'b0, 32'h0, 3, 4'b0001, 1);
    repeat (3) @(negedge PCLK);
    #3 PRESETn = 1'b0;
    #1;
    chk("arst_psel", 32'(bus.PSELx), 32'd0);
    chk("arst_penable", 32'(bus.PENABLE), 32'd0);
    chk("arst_mresp_valid", 32'(bus.MRESP_VALID), 32'd0);
    chk("arst_mready", 32'(bus.MREADY), 32'd0);
    q.delete();
    wait_n[0] = 0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    #1 chk("arst_rel_mready", 32'(bus.MREADY), 32'd1);
    repeat (5) @(negedge PCLK);
    prdata[0] = 32'h0BADF00D;
    req(1'b0, 32'h0000_0008, 32'h0, 4'hF, 1'b0, 32'h0BADF00D, 3, 4'b0001, 1);
    wait_done();
`ifdef APB_REQUESTER_TIMEOUT_EN
    wait_n[0] = 1000;
    req(1'b0, 32'h0000_0000, 32'h0, 4'hF, 1'b1, 32'h0, 10, 4'b0001, 8);
    wait_done();
    wait_n[0] = 0;
`endif
    repeat (3) @(negedge PCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_requester_mux.md
Name: apb_requester_mux

Overview:
Parametrised APB4 requester bridge. Accepts single transactions from a master/TB over a valid/ready request channel and returns results over a valid/ready response channel. Decodes the address into one of COMP completer regions and drives a one-hot PSELx. Muxes per-completer PREADY/PRDATA/PSLVERR and reports decode errors and slave errors back to the master.

Parameters:
ADDR_WIDTH, 32, address bits
DATA_WIDTH, 32, data bits; legal values 8, 16, 32
COMP, 4, number of completers; must be 1..16
REGION_BITS, 12, log2 of each completer's address window size
TIMEOUT_CYCLES, 256, wait-state limit (only used with the optional feature)

Ports:
PCLK  in  1  clock
PRESETn  in  1  async active-low reset
MVALID  in  1  request valid
MREADY  out  1  bridge can accept a request
MWRITE  in  1  1 = write, 0 = read
MADDR  in  ADDR_WIDTH  request address
MWDATA  in  DATA_WIDTH  write data
MSTRB  in  DATA_WIDTH/8  write byte strobes
MPROT  in  3  protection attributes
MRESP_VALID  out  1  response valid
MRESP_READY  in  1  master accepts response
MRDATA  out  DATA_WIDTH  read data (0 for writes and errors)
MERR  out  1  error flag (decode, slave or timeout)
PSELx  out  COMP  one-hot completer select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PSTRB  out  DATA_WIDTH/8  APB strobes; forced to 0 on reads
PPROT  out  3  APB protection
PREADY  in  COMP  per-completer ready
PSLVERR  in  COMP  per-completer error
PRDATA  in  COMP*DATA_WIDTH  per-completer read data; completer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset, asynchronous: FSM goes to IDLE. All outputs are 0, except MREADY = 1 after reset is released. Any in-flight transfer is abandoned with no response.
- Decode:
  - idx = MADDR[REGION_BITS +: clog2(COMP)] (idx = 0 when COMP = 1).
  - Hit requires every MADDR bit above the index field to be 0 and idx < COMP. Anything else is a decode error.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - MREADY = 1.
  - MVALID & MREADY registers MWRITE, MADDR, MWDATA, MSTRB, MPROT and idx.
  - Decode hit: next state SETUP. Decode error: next state RESP with MERR = 1 and MRDATA = 0; no APB activity.
- SETUP: PSELx[idx] = 1, PENABLE = 0, all P* outputs driven from the registered request. Next state is always ACCESS.
- ACCESS:
  - PSELx and PENABLE = 1; P* outputs held stable.
  - PREADY[idx] = 0: stay in ACCESS.
  - PREADY[idx] = 1: capture MERR = PSLVERR[idx]. Capture MRDATA = PRDATA slice idx if read and no error, else 0. Next state RESP.
- RESP:
  - PSELx = 0, PENABLE = 0, MRESP_VALID = 1. MRDATA and MERR are held stable until MRESP_READY.
  - MRESP_READY = 1 returns to IDLE. The next request can be accepted the following cycle; there is no request/response overlap.
- Latency with a zero-wait completer: accept at cycle N, SETUP at N+1, ACCESS at N+2, MRESP_VALID at N+3. Each wait state adds one cycle.
- MREADY = 0 in every state except IDLE. MVALID outside IDLE is ignored and the master must hold it.
- PREADY and PSLVERR of unselected completers are ignored.
- PADDR, PWDATA and PSTRB in IDLE/RESP hold the last registered values; they are don't-care for verification.

Optional Feature:
Macro APB_REQUESTER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY[idx] = 0.
  - When the counter reaches TIMEOUT_CYCLES-1 with PREADY still low, the bridge drops PSELx and PENABLE the next cycle and enters RESP with MERR = 1, MRDATA = 0.
  - PREADY arriving on the same cycle as the limit wins: normal completion.
- Not defined: no counter is instantiated and ACCESS waits indefinitely.

Test Plan:
- Write 0xDEADBEEF to 0x0000_1010, MSTRB = 0xF, completer 1 zero-wait -> PSELx = 0010 in SETUP/ACCESS, PENABLE high one cycle; MRESP_VALID at accept+3 with MERR = 0, MRDATA = 0.
- Read 0x0000_3004 with completer 3 inserting 3 wait states, PRDATA[3] = 0x12345678 -> ACCESS lasts 4 cycles; MRDATA = 0x12345678 at accept+6; PSTRB = 0 throughout.
- Read 0x0001_0000 (upper bits set) -> no PSELx assertion; MRESP_VALID at accept+1 with MERR = 1, MRDATA = 0.
- Write to completer 2 with PSLVERR[2] = 1 at PREADY, and MRESP_READY held low 5 cycles -> MERR = 1, response stable 5 cycles; MREADY = 0 until RESP exits.
- PRESETn pulsed low during ACCESS -> PSELx, PENABLE and MRESP_VALID clear asynchronously; MREADY = 1 after release; no stale response.
- With APB_REQUESTER_TIMEOUT_EN and TIMEOUT_CYCLES = 8, completer 0 never ready -> PENABLE drops after 8 ACCESS cycles; MERR = 1, MRDATA = 0.
